lock_commit_ctrl: RTL and testbench
===================================

// Module: lock_commit_ctrl
// PURPOSE
//  Upstream write/commit controller for a bank of NUM_REGS 8-bit lockable config registers.
//  Accepts write requests over a valid/ready channel and drives per-register wr_en plus shared data.
//  A two-step key sequence (ARM key, then COMMIT) asserts a sticky lock_en to the whole bank.
//  Every accepted request returns exactly one response, carrying an error flag.
// PARAMETERS
//  NUM_REGS  4     number of downstream lockable registers (>=1, <=2**ADDR_W)
//  ADDR_W    2     request address width
//  KEY       8'hA5 arm key value
// PORTS
//  clk         in   1         clock, all logic rising-edge
//  rst_n       in   1         asynchronous active-low reset
//  req_valid   in   1         request valid
//  req_ready   out  1         request ready
//  req_op      in   2         0=WRITE 1=ARM 2=COMMIT 3=reserved
//  req_addr    in   ADDR_W    register index (WRITE only)
//  req_data    in   8         write data, or key (ARM)
//  resp_valid  out  1         1-cycle response pulse
//  resp_err    out  1         response error flag, qualified by resp_valid
//  reg_wr_en   out  NUM_REGS  one-hot write strobe to register bank
//  reg_data    out  8         write data to register bank
//  reg_lock_en out  1         sticky lock to register bank
//  locked      out  1         status, equal to reg_lock_en
// BEHAVIOUR
//  Reset (async): state=IDLE; reg_wr_en=0; reg_data=0; reg_lock_en=0; locked=0; resp_valid=0;
//   resp_err=0; req_ready=0 while rst_n low, then 1 from first clock after release.
//  Accept = req_valid & req_ready. req_ready=1 only in IDLE and ARMED; 0 in ISSUE and LOCKED.
//  States: IDLE, ARMED, ISSUE, LOCKED.
//  IDLE:   WRITE, addr<NUM_REGS -> ISSUE. WRITE, addr>=NUM_REGS -> err resp, stay IDLE.
//          ARM, data==KEY -> ok resp, ARMED. ARM, wrong key -> err resp, stay IDLE.
//          COMMIT or op=3 -> err resp, stay IDLE.
//  ARMED:  COMMIT -> reg_lock_en=1 next cycle, ok resp, LOCKED.
//          Any other op -> err resp, disarm to IDLE; the request is NOT executed.
//  ISSUE:  reg_wr_en[addr]=1 and reg_data=data for exactly this one cycle; ok resp; -> IDLE.
//  LOCKED: terminal until rst_n. req_ready returns to 1 after one cycle; every request gets an
//          err resp and is discarded. reg_wr_en is never asserted while locked.
//  Latency: response 1 cycle after accept (ISSUE writes: resp in the same cycle as wr_en).
//          Throughput is 1 req/cycle except WRITE, which costs 2 cycles.
//  reg_data holds its last value when no write is in progress. reg_wr_en is one-hot or zero.
//  Lock and write never coincide; COMMIT is accepted only in ARMED, which has no write pending.
//  Reset mid-ISSUE: wr_en drops asynchronously; no partial write and no response.
// STRUCTURE
//  Shared package lock_pkg: op encodings (OP_WRITE/OP_ARM/OP_COMMIT), state enum, default KEY.
//  Sub-module: none. The address decode (addr -> one-hot wr_en) is an inline function.
//  Instantiates no lockable registers; the parent connects reg_* to the bank.
// TESTING
//  1. WRITE addr=2 data=8'h3C -> reg_wr_en=4'b0100, reg_data=8'h3C for 1 cycle; resp ok.
//  2. ARM 8'hA5, COMMIT -> reg_lock_en=1, locked=1; a following WRITE addr=0 gives err,
//     reg_wr_en stays 0.
//  3. ARM 8'h5A -> err, state IDLE; COMMIT -> err, reg_lock_en stays 0.
//  4. ARM 8'hA5 then WRITE addr=1 -> err, no wr_en; the next COMMIT -> err (disarmed).
//  5. WRITE addr=3 with NUM_REGS=3 -> err, no strobe; back-to-back ARM/COMMIT with continuous
//     req_valid -> two responses in consecutive cycles.
//  6. Locked, then rst_n pulse mid-cycle -> outputs at reset values immediately; a WRITE after
//     release succeeds.

Source files
------------

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared op encodings, FSM states and default key for lock_commit_ctrl
package lock_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_ARM    = 2'd1,
    OP_COMMIT = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  localparam logic [7:0] DEFAULT_KEY = 8'hA5;

endpackage

// File: rtl/lock_commit_ctrl_if.sv
// rtl/lock_commit_ctrl_if.sv - request/response channel between requester and lock_commit_ctrl
interface lock_commit_ctrl_if #(
  parameter int ADDR_W = 2
);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_data;
  logic              resp_valid;
  logic              resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_data,
    input  req_ready, resp_valid, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data,
    output req_ready, resp_valid, resp_err
  );

endinterface

// File: rtl/lock_commit_ctrl.sv
// rtl/lock_commit_ctrl.sv - write/commit controller driving strobes and a sticky lock to a register bank
module lock_commit_ctrl
  import lock_pkg::*;
#(
  parameter int         NUM_REGS = 4,
  parameter int         ADDR_W   = 2,
  parameter logic [7:0] KEY      = DEFAULT_KEY
) (
  input  logic                clk,
  input  logic                rst_n,
  lock_commit_ctrl_if.slave   bus,
  output logic [NUM_REGS-1:0] reg_wr_en,
  output logic [7:0]          reg_data,
  output logic                reg_lock_en,
  output logic                locked
);

  function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ADDR_W'(i) == a) oh[i] = 1'b1;
    return oh;
  endfunction

  state_e              state, state_n;
  logic                rdy_q, lock_rdy;
  logic                accept;
  logic [NUM_REGS-1:0] oh;
  logic [NUM_REGS-1:0] wr_en_n;
  logic [7:0]          data_n;
  logic                lock_n, rv_n, re_n;

  // Ready stays low during reset and for the first cycle after the lock is taken.
  assign bus.req_ready = rdy_q & ((state == ST_IDLE) | (state == ST_ARMED) |
                                  ((state == ST_LOCKED) & lock_rdy));
  assign accept = bus.req_valid & bus.req_ready;
  assign oh     = decode(bus.req_addr);
  assign locked = reg_lock_en;

  always_comb begin
    state_n = state;
    wr_en_n = '0;
    data_n  = reg_data;
    lock_n  = reg_lock_en;
    rv_n    = 1'b0;
    re_n    = 1'b0;
    case (state)
      ST_IDLE: if (accept) begin
        rv_n = 1'b1;
        case (bus.req_op)
          OP_WRITE: if (|oh) begin
            state_n = ST_ISSUE;
            wr_en_n = oh;
            data_n  = bus.req_data;
          end else begin
            re_n = 1'b1;
          end
          OP_ARM: if (bus.req_data == KEY) state_n = ST_ARMED;
                  else re_n = 1'b1;
          default: re_n = 1'b1;
        endcase
      end
      ST_ARMED: if (accept) begin
        rv_n = 1'b1;
        if (bus.req_op == OP_COMMIT) begin
          lock_n  = 1'b1;
          state_n = ST_LOCKED;
        end else begin
          re_n    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      // Strobe and response were registered at accept; this cycle only stalls the channel.
      ST_ISSUE: state_n = ST_IDLE;
      ST_LOCKED: if (accept) begin
        rv_n = 1'b1;
        re_n = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rdy_q          <= 1'b0;
      lock_rdy       <= 1'b0;
      reg_wr_en      <= '0;
      reg_data       <= 8'h00;
      reg_lock_en    <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
    end else begin
      state          <= state_n;
      rdy_q          <= 1'b1;
      lock_rdy       <= (state == ST_LOCKED);
      reg_wr_en      <= wr_en_n;
      reg_data       <= data_n;
      reg_lock_en    <= lock_n;
      bus.resp_valid <= rv_n;
      bus.resp_err   <= re_n;
    end
  end

endmodule

// File: tb/tb_lock_commit_ctrl.sv
// tb/tb_lock_commit_ctrl.sv - directed self-checking bench for lock_commit_ctrl
module tb_lock_commit_ctrl;
  import lock_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] wr_a;
  logic [7:0] data_a;
  logic       lock_a, locked_a;
  logic [2:0] wr_b;
  logic [7:0] data_b;
  logic       lock_b, locked_b;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  lock_commit_ctrl_if #(.ADDR_W(2)) ifa ();
  lock_commit_ctrl_if #(.ADDR_W(2)) ifb ();

  lock_commit_ctrl #(.NUM_REGS(4), .ADDR_W(2), .KEY(8'hA5)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
    .reg_wr_en(wr_a), .reg_data(data_a), .reg_lock_en(lock_a), .locked(locked_a)
  );

  lock_commit_ctrl #(.NUM_REGS(3), .ADDR_W(2), .KEY(8'hA5)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave),
    .reg_wr_en(wr_b), .reg_data(data_b), .reg_lock_en(lock_b), .locked(locked_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic req_a(input string tag, input logic [1:0] op, input logic [1:0] addr,
                       input logic [7:0] data, input logic exp_err, input logic [3:0] exp_wr);
    @(negedge clk);
    check({tag, ".ready"}, 32'(ifa.req_ready), 32'd1);
    check({tag, ".idle_wr"}, 32'(wr_a), 32'd0);
    check({tag, ".idle_rv"}, 32'(ifa.resp_valid), 32'd0);
    ifa.req_valid = 1'b1; ifa.req_op = op; ifa.req_addr = addr; ifa.req_data = data;
    @(negedge clk);
    ifa.req_valid = 1'b0;
    check({tag, ".rv"}, 32'(ifa.resp_valid), 32'd1);
    check({tag, ".err"}, 32'(ifa.resp_err), 32'(exp_err));
    check({tag, ".wr"}, 32'(wr_a), 32'(exp_wr));
    if (exp_wr != 4'd0) check({tag, ".data"}, 32'(data_a), 32'(data));
  endtask

  task automatic req_b(input string tag, input logic [1:0] addr, input logic [7:0] data,
                       input logic exp_err, input logic [2:0] exp_wr);
    @(negedge clk);
    check({tag, ".ready"}, 32'(ifb.req_ready), 32'd1);
    ifb.req_valid = 1'b1; ifb.req_op = OP_WRITE; ifb.req_addr = addr; ifb.req_data = data;
    @(negedge clk);
    ifb.req_valid = 1'b0;
    check({tag, ".rv"}, 32'(ifb.resp_valid), 32'd1);
    check({tag, ".err"}, 32'(ifb.resp_err), 32'(exp_err));
    check({tag, ".wr"}, 32'(wr_b), 32'(exp_wr));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ifa.req_valid = 1'b0; ifa.req_op = 2'd0; ifa.req_addr = 2'd0; ifa.req_data = 8'h00;
    ifb.req_valid = 1'b0; ifb.req_op = 2'd0; ifb.req_addr = 2'd0; ifb.req_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst.ready", 32'(ifa.req_ready), 32'd0);
    check("rst.wr", 32'(wr_a), 32'd0);
    check("rst.data", 32'(data_a), 32'd0);
    check("rst.lock", 32'(lock_a), 32'd0);
    check("rst.rv", 32'(ifa.resp_valid), 32'd0);
    rst_n = 1'b1;

    req_a("t1_write", OP_WRITE, 2'd2, 8'h3C, 1'b0, 4'b0100);
    req_a("t3_badkey", OP_ARM, 2'd0, 8'h5A, 1'b1, 4'b0000);
    req_a("t3_commit", OP_COMMIT, 2'd0, 8'h00, 1'b1, 4'b0000);
    check("t3.lock", 32'(lock_a), 32'd0);
    req_a("t4_arm", OP_ARM, 2'd0, 8'hA5, 1'b0, 4'b0000);
    req_a("t4_write", OP_WRITE, 2'd1, 8'h77, 1'b1, 4'b0000);
    check("t4.hold", 32'(data_a), 32'h3C);
    req_a("t4_commit", OP_COMMIT, 2'd0, 8'h00, 1'b1, 4'b0000);
    req_a("rsvd", OP_RSVD, 2'd0, 8'h00, 1'b1, 4'b0000);
    req_a("w3", OP_WRITE, 2'd3, 8'hE1, 1'b0, 4'b1000);
    req_a("w0", OP_WRITE, 2'd0, 8'h42, 1'b0, 4'b0001);

    req_b("t5_oob", 2'd3, 8'h99, 1'b1, 3'b000);
    req_b("t5_w2", 2'd2, 8'h66, 1'b0, 3'b100);

    @(negedge clk);
    ifa.req_valid = 1'b1; ifa.req_op = OP_ARM; ifa.req_data = 8'hA5;
    @(negedge clk);
    check("t5.arm_rv", 32'(ifa.resp_valid), 32'd1);
    check("t5.arm_err", 32'(ifa.resp_err), 32'd0);
    check("t5.armed_ready", 32'(ifa.req_ready), 32'd1);
    ifa.req_op = OP_COMMIT;
    @(negedge clk);
    ifa.req_valid = 1'b0;
    check("t5.commit_rv", 32'(ifa.resp_valid), 32'd1);
    check("t5.commit_err", 32'(ifa.resp_err), 32'd0);
    check("t2.lock", 32'(lock_a), 32'd1);
    check("t2.locked", 32'(locked_a), 32'd1);
    check("t2.lock_ready", 32'(ifa.req_ready), 32'd0);
    req_a("t2_write", OP_WRITE, 2'd0, 8'hFF, 1'b1, 4'b0000);
    req_a("t2_arm", OP_ARM, 2'd0, 8'hA5, 1'b1, 4'b0000);
    check("t2.sticky", 32'(lock_a), 32'd1);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6.lock", 32'(lock_a), 32'd0);
    check("t6.locked", 32'(locked_a), 32'd0);
    check("t6.ready", 32'(ifa.req_ready), 32'd0);
    check("t6.data", 32'(data_a), 32'd0);
    check("t6.rv", 32'(ifa.resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_a("t6_write", OP_WRITE, 2'd0, 8'h11, 1'b0, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
